// File: rtl/sram_ctrl_ws_pkg.sv
// Shared SRAM timing defaults, FSM state type and the ns-to-cycles conversion
// used to size every wait-state phase at elaboration.
package sram_timings_pkg;

  localparam int unsigned DEF_CLK_PERIOD = 10;
  localparam int unsigned DEF_T_AA       = 10;
  localparam int unsigned DEF_T_WP       = 8;
  localparam int unsigned DEF_T_SU       = 2;
  localparam int unsigned DEF_T_HD       = 2;
  localparam int unsigned DEF_T_TA       = 5;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_TURN,
    ST_WR_SU,
    ST_WR_PW,
    ST_WR_HD
  } state_e;

  // Whole clock cycles covering t_ns, never less than one.
  function automatic int unsigned cycles(input int unsigned t_ns, input int unsigned clk_ns);
    int unsigned c;
    c = (t_ns + clk_ns - 1) / clk_ns;
    return (c == 0) ? 1 : c;
  endfunction

endpackage

// File: rtl/sram_ctrl_ws_counter.sv
// Loadable down counter shared by every wait-state phase; done_o marks the
// last cycle of the loaded phase length.
module sram_ws_counter
  import sram_timings_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/sram_ctrl_ws.sv
// Avalon-MM slave to asynchronous SRAM bridge: one transaction at a time,
// wait states derived from ns timings, registered SRAM pins and byte lanes.
module sram_ctrl_ws
  import sram_timings_pkg::*;
#(
  parameter int unsigned CLK_PERIOD = DEF_CLK_PERIOD,
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned T_AA       = DEF_T_AA,
  parameter int unsigned T_WP       = DEF_T_WP,
  parameter int unsigned T_SU       = DEF_T_SU,
  parameter int unsigned T_HD       = DEF_T_HD,
  parameter int unsigned T_TA       = DEF_T_TA
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_W-1:0]     avs_address_i,
  input  logic                  avs_read_i,
  input  logic                  avs_write_i,
  input  logic [DATA_W-1:0]     avs_writedata_i,
  input  logic [DATA_W/8-1:0]   avs_byteenable_i,
  output logic                  avs_waitrequest_o,
  output logic [DATA_W-1:0]     avs_readdata_o,
  output logic                  avs_readdatavalid_o,
  output logic                  wen_o,
  output logic                  oen_o,
  output logic [DATA_W/8-1:0]   ben_o,
  output logic [ADDR_W-1:0]     addr_o,
  output logic                  data_en_o,
  output logic [DATA_W-1:0]     data_o,
  input  logic [DATA_W-1:0]     data_i
);

  localparam int unsigned BE_W = DATA_W / 8;

  localparam logic [CNT_W-1:0] RD_N = CNT_W'(cycles(T_AA, CLK_PERIOD));
  localparam logic [CNT_W-1:0] WP_N = CNT_W'(cycles(T_WP, CLK_PERIOD));
  localparam logic [CNT_W-1:0] SU_N = CNT_W'(cycles(T_SU, CLK_PERIOD));
  localparam logic [CNT_W-1:0] HD_N = CNT_W'(cycles(T_HD, CLK_PERIOD));
  localparam logic [CNT_W-1:0] TA_N = CNT_W'(cycles(T_TA, CLK_PERIOD));

  state_e             state_q, state_d;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_done;

  logic               wen_q, wen_d;
  logic               oen_q, oen_d;
  logic [BE_W-1:0]    ben_q, ben_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               den_q, den_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rdv_q, rdv_d;

  sram_ws_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write has priority over read when both are requested in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (avs_write_i) begin
          state_d  = ST_WR_SU;
          cnt_load = 1'b1;
          cnt_val  = SU_N;
        end else if (avs_read_i) begin
          state_d  = ST_RD;
          cnt_load = 1'b1;
          cnt_val  = RD_N;
        end
      end
      ST_RD: begin
        if (cnt_done) begin
          state_d  = ST_TURN;
          cnt_load = 1'b1;
          cnt_val  = TA_N;
        end
      end
      ST_TURN:  if (cnt_done) state_d = ST_IDLE;
      ST_WR_SU: begin
        if (cnt_done) begin
          state_d  = ST_WR_PW;
          cnt_load = 1'b1;
          cnt_val  = WP_N;
        end
      end
      ST_WR_PW: begin
        if (cnt_done) begin
          state_d  = ST_WR_HD;
          cnt_load = 1'b1;
          cnt_val  = HD_N;
        end
      end
      ST_WR_HD: if (cnt_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pin next-values are decided on phase boundaries so every SRAM pin leaves a flop.
  always_comb begin
    avs_waitrequest_o = rst_i || (state_q != ST_IDLE);
    wen_d   = wen_q;
    oen_d   = oen_q;
    ben_d   = ben_q;
    addr_d  = addr_q;
    den_d   = den_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avs_write_i) begin
          addr_d  = avs_address_i;
          ben_d   = ~avs_byteenable_i;
          wdata_d = avs_writedata_i;
          den_d   = 1'b1;
        end else if (avs_read_i) begin
          addr_d = avs_address_i;
          ben_d  = '0;
          oen_d  = 1'b0;
        end
      end
      ST_RD: begin
        if (cnt_done) begin
          oen_d   = 1'b1;
          rdata_d = data_i;
          rdv_d   = 1'b1;
        end
      end
      ST_WR_SU: if (cnt_done) wen_d = 1'b0;
      ST_WR_PW: if (cnt_done) wen_d = 1'b1;
      ST_WR_HD: if (cnt_done) den_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
      ben_q   <= '1;
      addr_q  <= '0;
      den_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      ben_q   <= ben_d;
      addr_q  <= addr_d;
      den_q   <= den_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
    end
  end

  assign wen_o               = wen_q;
  assign oen_o               = oen_q;
  assign ben_o               = ben_q;
  assign addr_o              = addr_q;
  assign data_en_o           = den_q;
  assign data_o              = wdata_q;
  assign avs_readdata_o      = rdata_q;
  assign avs_readdatavalid_o = rdv_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_IDLE) begin
        assert (!(avs_read_i && avs_write_i))
          else $warning("sram_ctrl_ws: read and write requested together, read dropped");
      end
      assert (!(den_q && !oen_q))
        else $error("sram_ctrl_ws: data pads driven while SRAM output enabled");
    end
  end

endmodule
